// File: rtl/register_write.sv
// register_write: write side and storage of the MIPS GPR file plus HI/LO.
//
// One GPR write port is shared between the ALU/write-back result (alu_*)
// and late load results (ld_*). If a load arrives in the same cycle as an
// ALU write to a different register, the load is held in a one-entry buffer
// (pend_*). The buffer commits on the next cycle without an ALU write.
// r0 is hardwired to zero.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   alu_we/addr/data  ALU result, committed whenever alu_we is high
//   ld_valid/addr/data, ld_ready
//                     load channel, valid/ready handshake
//   hilo_we, hi_data, lo_data
//                     HI/LO write, both registers load together
//   out_register      committed GPR array [0:31]
//   out_hi, out_lo    committed HI/LO
//   pend_valid, pend_addr
//                     buffered-load status (pend_addr is 0 when empty)
module register_write #(
    parameter logic [31:0] GP_RESET = 32'h1000_8000,
    parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_we,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        hilo_we,
    input  logic [31:0] hi_data,
    input  logic [31:0] lo_data,
    output logic [31:0] out_register [0:31],
    output logic [31:0] out_hi,
    output logic [31:0] out_lo,
    output logic        pend_valid,
    output logic [4:0]  pend_addr
);

    logic [31:0] pend_data;

    logic        ld_fire;
    logic        wr_req;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pend_capture;
    logic        pend_clear;

    assign ld_ready = ~pend_valid;

    // Age order: ALU write (youngest) > incoming load > buffered load.
    // The younger value wins on an address match, so the older one is dropped.
    always_comb begin
        ld_fire      = ld_valid & ~pend_valid;
        wr_req       = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        pend_capture = 1'b0;
        pend_clear   = 1'b0;

        if (pend_valid) begin
            if (alu_we) begin
                wr_req  = 1'b1;
                wr_addr = alu_addr;
                wr_data = alu_data;
                if (alu_addr == pend_addr) begin
                    pend_clear = 1'b1;
                end
            end else begin
                wr_req     = 1'b1;
                wr_addr    = pend_addr;
                wr_data    = pend_data;
                pend_clear = 1'b1;
            end
        end else if (alu_we) begin
            wr_req  = 1'b1;
            wr_addr = alu_addr;
            wr_data = alu_data;
            // A load to r0 completes its handshake but is never buffered.
            if (ld_fire && (ld_addr != alu_addr) && (ld_addr != 5'd0)) begin
                pend_capture = 1'b1;
            end
        end else if (ld_fire) begin
            wr_req  = 1'b1;
            wr_addr = ld_addr;
            wr_data = ld_data;
        end

        wr_en = wr_req & (wr_addr != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                out_register[i[4:0]] <= (i == 28) ? GP_RESET :
                                        (i == 29) ? SP_RESET : '0;
            end
        end else if (wr_en) begin
            out_register[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else if (pend_capture) begin
            pend_valid <= 1'b1;
            pend_addr  <= ld_addr;
            pend_data  <= ld_data;
        end else if (pend_clear) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hi <= '0;
            out_lo <= '0;
        end else if (hilo_we) begin
            out_hi <= hi_data;
            out_lo <= lo_data;
        end
    end

endmodule

// File: tb/tb_register_write.sv
// tb_register_write: directed bench for register_write. Expected values are
// queued as stimulus is driven and compared after the following clock edge
// (or immediately for asynchronous reset checks).
module tb_register_write;

    logic        clk;
    logic        rst_n;
    logic        alu_we;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        hilo_we;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
    logic [31:0] out_register [0:31];
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic        pend_valid;
    logic [4:0]  pend_addr;

    register_write #(
        .GP_RESET(32'h1000_8000),
        .SP_RESET(32'h7FFF_EFFC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alu_we(alu_we),
        .alu_addr(alu_addr),
        .alu_data(alu_data),
        .ld_valid(ld_valid),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .ld_ready(ld_ready),
        .hilo_we(hilo_we),
        .hi_data(hi_data),
        .lo_data(lo_data),
        .out_register(out_register),
        .out_hi(out_hi),
        .out_lo(out_lo),
        .pend_valid(pend_valid),
        .pend_addr(pend_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int SEL_REG   = 0;
    localparam int SEL_PV    = 1;
    localparam int SEL_PA    = 2;
    localparam int SEL_RDY   = 3;
    localparam int SEL_HI    = 4;
    localparam int SEL_LO    = 5;

    typedef struct {
        string       tag;
        int          sel;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic exp_reg(input string tag, input int idx, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = SEL_REG; e.idx = idx; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic exp_sig(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.idx = 0; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic exp_pend(input string tag, input logic pv, input logic [4:0] pa);
        exp_sig({tag, "_pv"}, SEL_PV, {31'd0, pv});
        exp_sig({tag, "_pa"}, SEL_PA, {27'd0, pa});
        exp_sig({tag, "_rdy"}, SEL_RDY, {31'd0, ~pv});
    endtask

    function automatic logic [31:0] observe(input exp_t e);
        case (e.sel)
            SEL_REG: return out_register[e.idx];
            SEL_PV:  return {31'd0, pend_valid};
            SEL_PA:  return {27'd0, pend_addr};
            SEL_RDY: return {31'd0, ld_ready};
            SEL_HI:  return out_hi;
            SEL_LO:  return out_lo;
            default: return 'x;
        endcase
    endfunction

    // Pops and compares every queued expectation against the current outputs.
    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e);
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_we   = 1'b0;
        alu_addr = '0;
        alu_data = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        hilo_we  = 1'b0;
        hi_data  = '0;
        lo_data  = '0;
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d);
        alu_we = 1'b1; alu_addr = a; alu_data = d;
    endtask

    task automatic ld(input logic [4:0] a, input logic [31:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b1;

        // 1. Asynchronous reset mid-cycle and the r0 hardwiring.
        #12 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            exp_reg($sformatf("rst_r%0d", i), i,
                    (i == 28) ? 32'h1000_8000 : (i == 29) ? 32'h7FFF_EFFC : 32'h0);
        end
        exp_pend("rst", 1'b0, 5'd0);
        exp_sig("rst_hi", SEL_HI, 32'h0);
        exp_sig("rst_lo", SEL_LO, 32'h0);
        check();
        @(negedge clk) rst_n = 1'b1;

        alu(5'd0, 32'hDEAD_BEEF);
        exp_reg("r0_alu", 0, 32'h0);
        step(); idle_inputs(); check();

        // 2. Single ALU write, then single load.
        alu(5'd5, 32'h1234_5678);
        exp_reg("r5_before", 5, 32'h0);
        check();
        exp_reg("r5_after", 5, 32'h1234_5678);
        step(); idle_inputs(); check();

        ld(5'd6, 32'hCAFE_0001);
        exp_reg("r6_load", 6, 32'hCAFE_0001);
        exp_pend("r6_load", 1'b0, 5'd0);
        step(); idle_inputs(); check();

        // 3. Collision on different addresses; a new load waits for ld_ready.
        alu(5'd7, 32'h11);
        ld(5'd8, 32'h22);
        exp_reg("coll_r7", 7, 32'h11);
        exp_reg("coll_r8_pending", 8, 32'h0);
        exp_pend("coll", 1'b1, 5'd8);
        step(); idle_inputs();
        check();
        ld(5'd16, 32'h1616);
        exp_reg("drain_r8", 8, 32'h22);
        exp_reg("drain_r16_blocked", 16, 32'h0);
        exp_pend("drain", 1'b0, 5'd0);
        step(); check();
        exp_reg("late_r16", 16, 32'h1616);
        exp_pend("late", 1'b0, 5'd0);
        step(); idle_inputs(); check();

        // 4. Collision on the same address: ALU wins, load dropped.
        alu(5'd9, 32'hAA);
        ld(5'd9, 32'hBB);
        exp_reg("same_r9", 9, 32'hAA);
        exp_pend("same", 1'b0, 5'd0);
        step(); idle_inputs(); check();
        exp_reg("same_r9_hold", 9, 32'hAA);
        step(); check();

        // Load to r0 colliding with an ALU write is never buffered.
        alu(5'd4, 32'h44);
        ld(5'd0, 32'h55);
        exp_reg("r0coll_r4", 4, 32'h44);
        exp_reg("r0coll_r0", 0, 32'h0);
        exp_pend("r0coll", 1'b0, 5'd0);
        step(); idle_inputs(); check();

        // 5. Stale buffer superseded by a younger ALU write.
        alu(5'd1, 32'h1);
        ld(5'd10, 32'h5);
        exp_pend("stale_fill", 1'b1, 5'd10);
        exp_reg("stale_r10_pre", 10, 32'h0);
        step(); idle_inputs(); check();
        alu(5'd10, 32'h6);
        exp_reg("stale_r10", 10, 32'h6);
        exp_pend("stale_clr", 1'b0, 5'd0);
        step(); idle_inputs(); check();
        exp_reg("stale_r10_hold", 10, 32'h6);
        step(); check();

        // 6. Buffer held by consecutive ALU writes, then reset drops it.
        alu(5'd3, 32'h33);
        ld(5'd11, 32'h111);
        exp_pend("hold_fill", 1'b1, 5'd11);
        step(); idle_inputs(); check();
        for (int k = 0; k < 3; k++) begin
            alu(5'(12 + k), 32'h1200 + 32'(k));
            exp_reg($sformatf("hold_r%0d", 12 + k), 12 + k, 32'h1200 + 32'(k));
            exp_reg($sformatf("hold_r11_%0d", k), 11, 32'h0);
            exp_pend($sformatf("hold_%0d", k), 1'b1, 5'd11);
            step(); check();
        end
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        exp_pend("hold_rst", 1'b0, 5'd0);
        exp_reg("hold_rst_r11", 11, 32'h0);
        exp_reg("hold_rst_r12", 12, 32'h0);
        exp_reg("hold_rst_r28", 28, 32'h1000_8000);
        check();
        @(negedge clk) rst_n = 1'b1;
        exp_pend("post_rst", 1'b0, 5'd0);
        exp_reg("post_rst_r11", 11, 32'h0);
        step(); check();

        // HI/LO write and hold.
        hilo_we = 1'b1; hi_data = 32'h1; lo_data = 32'h2;
        exp_sig("hi_pre", SEL_HI, 32'h0);
        check();
        exp_sig("hi_wr", SEL_HI, 32'h1);
        exp_sig("lo_wr", SEL_LO, 32'h2);
        step();
        hilo_we = 1'b0; hi_data = 32'h9; lo_data = 32'h9;
        check();
        exp_sig("hi_hold", SEL_HI, 32'h1);
        exp_sig("lo_hold", SEL_LO, 32'h2);
        step(); idle_inputs(); check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
